spi_master_arb: RTL and testbench

Two-requester arbiter and sequencer in front of `spi_master`. It shares the single SPI master between two client ports, for example a flash loader and a register-access engine. Each command descriptor is latched at grant and `spi_start` is issued. Write-data requests and read-data beats are steered to the owning client, and a done/error pulse is returned when the transaction ends or the master fails to respond.

---
 rtl/spi_arb_pkg.sv | 20 ++
 rtl/spi_arb_sel.sv | 58 +++++
 rtl/spi_master_arb.sv | 155 +++++++++++++++
 tb/tb_spi_master_arb.sv | 360 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_arb_pkg.sv
// Shared state encoding, widths and a routing helper for the two-client SPI master arbiter.
package spi_arb_pkg;

    localparam int SPI_CMD_W = 8;
    localparam int SPI_LEN_W = 12;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        WAIT_BUSY = 3'd2,
        RUN       = 3'd3,
        DONE      = 3'd4
    } arb_state_t;

    // Master strobes may only reach a client while its transaction is in flight.
    function automatic logic route_active(input arb_state_t st);
        return (st == WAIT_BUSY) || (st == RUN);
    endfunction

endpackage

// File: rtl/spi_arb_sel.sv
// Winner select for the two clients; with SPI_ARB_RR_EN a last-served pointer breaks ties,
// otherwise client 0 always wins and no state is kept.
module spi_arb_sel
    import spi_arb_pkg::*;
(
`ifdef SPI_ARB_RR_EN
    input  logic clk,
    input  logic rst,
    input  logic take,
`endif
    input  logic req0,
    input  logic req1,
    output logic any,
    output logic winner
);

    assign any = req0 | req1;

`ifdef SPI_ARB_RR_EN
    logic last_r;

    // Last-served pointer; resets to "client 1 served" so client 0 wins the first tie.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_r <= 1'b1;
        end else if (take) begin
            last_r <= winner;
        end else begin
            last_r <= last_r;
        end
    end

    // Tie goes to the client not served last.
    always_comb begin
        winner = 1'b0;
        if (req0 && req1) begin
            winner = ~last_r;
        end else if (req1) begin
            winner = 1'b1;
        end else begin
            winner = 1'b0;
        end
    end
`else
    // Fixed priority: client 1 wins only when client 0 is not requesting.
    always_comb begin
        winner = 1'b0;
        if (req0) begin
            winner = 1'b0;
        end else if (req1) begin
            winner = 1'b1;
        end else begin
            winner = 1'b0;
        end
    end
`endif

endmodule

// File: rtl/spi_master_arb.sv
// Two-client arbiter/sequencer in front of spi_master: grant, start, route data, report done/error.
// Build option: define SPI_ARB_RR_EN for round-robin ties (default is fixed priority, client 0 first).
module spi_master_arb
    import spi_arb_pkg::*;
#(
    parameter int ADDR_WIDTH   = 24,
    parameter int LEN_WIDTH    = SPI_LEN_W,
    parameter int BUSY_TIMEOUT = 15
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  c0_req,
    input  logic [SPI_CMD_W-1:0]  c0_cmd,
    input  logic [ADDR_WIDTH-1:0] c0_addr,
    input  logic [LEN_WIDTH-1:0]  c0_length,
    output logic                  c0_gnt,
    output logic                  c0_done,
    output logic                  c0_err,
    output logic                  c0_wr_req,
    input  logic [7:0]            c0_wr_data,
    output logic                  c0_rd_vld,
    output logic [7:0]            c0_rd_data,
    input  logic                  c1_req,
    input  logic [SPI_CMD_W-1:0]  c1_cmd,
    input  logic [ADDR_WIDTH-1:0] c1_addr,
    input  logic [LEN_WIDTH-1:0]  c1_length,
    output logic                  c1_gnt,
    output logic                  c1_done,
    output logic                  c1_err,
    output logic                  c1_wr_req,
    input  logic [7:0]            c1_wr_data,
    output logic                  c1_rd_vld,
    output logic [7:0]            c1_rd_data,
    output logic                  spi_start,
    output logic [SPI_CMD_W-1:0]  spi_cmd,
    output logic [ADDR_WIDTH-1:0] spi_addr,
    output logic [LEN_WIDTH-1:0]  spi_length,
    input  logic                  spi_busy,
    input  logic                  spi_wr_req,
    output logic [7:0]            spi_wr_data,
    input  logic                  spi_rd_vld,
    input  logic [7:0]            spi_rd_data
);

    localparam int CNT_W = (BUSY_TIMEOUT > 1) ? $clog2(BUSY_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BUSY_TIMEOUT - 1);

    arb_state_t       state_r;
    logic             owner_r;
    logic [CNT_W-1:0] cnt_r;
    logic             any_req_s;
    logic             winner_s;
    logic             start_ok_s;
    logic             route_s;

    assign start_ok_s = (state_r == IDLE) && any_req_s && !spi_busy;

    spi_arb_sel u_sel (
`ifdef SPI_ARB_RR_EN
        .clk    (clk),
        .rst    (rst),
        .take   (start_ok_s),
`endif
        .req0   (c0_req),
        .req1   (c1_req),
        .any    (any_req_s),
        .winner (winner_s)
    );

    // Transaction sequencer; every client/master pulse is registered here.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r    <= IDLE;
            owner_r    <= 1'b0;
            cnt_r      <= '0;
            spi_start  <= 1'b0;
            spi_cmd    <= '0;
            spi_addr   <= '0;
            spi_length <= '0;
            c0_gnt     <= 1'b0;
            c1_gnt     <= 1'b0;
            c0_done    <= 1'b0;
            c1_done    <= 1'b0;
            c0_err     <= 1'b0;
            c1_err     <= 1'b0;
        end else begin
            spi_start <= 1'b0;
            c0_gnt    <= 1'b0;
            c1_gnt    <= 1'b0;
            c0_done   <= 1'b0;
            c1_done   <= 1'b0;
            c0_err    <= 1'b0;
            c1_err    <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (start_ok_s) begin
                        state_r    <= START;
                        owner_r    <= winner_s;
                        spi_start  <= 1'b1;
                        c0_gnt     <= ~winner_s;
                        c1_gnt     <= winner_s;
                        spi_cmd    <= winner_s ? c1_cmd    : c0_cmd;
                        spi_addr   <= winner_s ? c1_addr   : c0_addr;
                        spi_length <= winner_s ? c1_length : c0_length;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                START: begin
                    state_r <= WAIT_BUSY;
                    cnt_r   <= '0;
                end
                WAIT_BUSY: begin
                    // Counter reaches its last value on the final allowed cycle.
                    if (spi_busy) begin
                        state_r <= RUN;
                    end else if (cnt_r == CNT_LAST) begin
                        state_r <= DONE;
                        c0_done <= ~owner_r;
                        c1_done <= owner_r;
                        c0_err  <= ~owner_r;
                        c1_err  <= owner_r;
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
                RUN: begin
                    if (!spi_busy) begin
                        state_r <= DONE;
                        c0_done <= ~owner_r;
                        c1_done <= owner_r;
                    end else begin
                        state_r <= RUN;
                    end
                end
                DONE: begin
                    state_r <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign route_s     = route_active(state_r);
    assign c0_wr_req   = spi_wr_req & route_s & ~owner_r;
    assign c1_wr_req   = spi_wr_req & route_s & owner_r;
    assign c0_rd_vld   = spi_rd_vld & route_s & ~owner_r;
    assign c1_rd_vld   = spi_rd_vld & route_s & owner_r;
    assign c0_rd_data  = spi_rd_data;
    assign c1_rd_data  = spi_rd_data;
    assign spi_wr_data = owner_r ? c1_wr_data : c0_wr_data;

endmodule

// File: tb/tb_spi_master_arb.sv
// Scoreboard bench for spi_master_arb with a behavioural SPI master model.
module tb_spi_master_arb;

    localparam int ADDR_WIDTH   = 24;
    localparam int LEN_WIDTH    = 12;
    localparam int BUSY_TIMEOUT = 15;

    logic clk, rst;
    logic c0_req, c1_req;
    logic [7:0] c0_cmd, c1_cmd;
    logic [ADDR_WIDTH-1:0] c0_addr, c1_addr;
    logic [LEN_WIDTH-1:0] c0_length, c1_length;
    logic c0_gnt, c1_gnt, c0_done, c1_done, c0_err, c1_err;
    logic c0_wr_req, c1_wr_req, c0_rd_vld, c1_rd_vld;
    logic [7:0] c0_wr_data, c1_wr_data, c0_rd_data, c1_rd_data;
    logic spi_start, spi_busy, spi_wr_req, spi_rd_vld;
    logic [7:0] spi_cmd, spi_wr_data, spi_rd_data;
    logic [ADDR_WIDTH-1:0] spi_addr;
    logic [LEN_WIDTH-1:0] spi_length;

    spi_master_arb #(.ADDR_WIDTH(ADDR_WIDTH), .LEN_WIDTH(LEN_WIDTH), .BUSY_TIMEOUT(BUSY_TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .c0_req(c0_req), .c0_cmd(c0_cmd), .c0_addr(c0_addr), .c0_length(c0_length),
        .c0_gnt(c0_gnt), .c0_done(c0_done), .c0_err(c0_err), .c0_wr_req(c0_wr_req),
        .c0_wr_data(c0_wr_data), .c0_rd_vld(c0_rd_vld), .c0_rd_data(c0_rd_data),
        .c1_req(c1_req), .c1_cmd(c1_cmd), .c1_addr(c1_addr), .c1_length(c1_length),
        .c1_gnt(c1_gnt), .c1_done(c1_done), .c1_err(c1_err), .c1_wr_req(c1_wr_req),
        .c1_wr_data(c1_wr_data), .c1_rd_vld(c1_rd_vld), .c1_rd_data(c1_rd_data),
        .spi_start(spi_start), .spi_cmd(spi_cmd), .spi_addr(spi_addr), .spi_length(spi_length),
        .spi_busy(spi_busy), .spi_wr_req(spi_wr_req), .spi_wr_data(spi_wr_data),
        .spi_rd_vld(spi_rd_vld), .spi_rd_data(spi_rd_data)
    );

    typedef struct packed {
        logic                  client;
        logic [7:0]            cmd;
        logic [ADDR_WIDTH-1:0] addr;
        logic [LEN_WIDTH-1:0]  len;
        logic                  err;
    } exp_t;

    exp_t exp_q[$];
    exp_t cur;
    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int start_cyc = 0;
    int done_cyc = 0;
    int gap_from_done = 0;
    int rd_cnt0, rd_cnt1, wr_cnt0, wr_cnt1;
    logic txn_open = 1'b0;
    logic prev_start = 1'b0;
    logic [10:0] strobes_s;
    logic [43:0] desc_s;

    // Master model configuration and state.
    int m_busy_len = 10;
    int m_beats = 0;
    int m_cnt, m_left;
    logic m_read = 1'b1;
    logic m_never = 1'b0;
    logic m_active;

    assign strobes_s = {spi_start, c0_gnt, c1_gnt, c0_done, c1_done, c0_err, c1_err,
                        c0_wr_req, c1_wr_req, c0_rd_vld, c1_rd_vld};
    assign desc_s = {spi_cmd, spi_addr, spi_length};

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%0h want=%0h", tag, got, want);
        end
    endtask

    task automatic push_exp(input logic who, input logic err);
        exp_t e;
        e.client = who;
        e.cmd    = who ? c1_cmd : c0_cmd;
        e.addr   = who ? c1_addr : c0_addr;
        e.len    = who ? c1_length : c0_length;
        e.err    = err;
        exp_q.push_back(e);
    endtask

    // Raise one client's request from IDLE, check one-cycle grant latency, drop after grant.
    task automatic req_one(input logic who, input string tag);
        int c;
        int guard;
        @(posedge clk); #1;
        c = cyc;
        if (who) c1_req = 1'b1; else c0_req = 1'b1;
        guard = 0;
        do begin
            @(negedge clk);
            guard++;
        end while (!(c0_gnt || c1_gnt) && guard < 100);
        #1;
        check_val({tag, "_lat"}, 64'(start_cyc), 64'(c + 1));
        @(posedge clk); #1;
        if (who) c1_req = 1'b0; else c0_req = 1'b0;
    endtask

    task automatic wait_quiet(input string tag);
        int guard;
        logic quiet;
        guard = 0;
        quiet = 1'b0;
        while (!quiet && guard < 400) begin
            @(negedge clk); #1;
            guard++;
            quiet = !txn_open && (exp_q.size() == 0);
        end
        check_val({tag, "_quiet"}, 64'(quiet), 64'(1));
    endtask

    task automatic do_reset();
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        exp_q.delete();
        txn_open = 1'b0;
        rst = 1'b1;
    endtask

    task automatic run_both(input int n);
        int got;
        int guard;
        got = 0;
        guard = 0;
        @(posedge clk); #1;
        c0_req = 1'b1;
        c1_req = 1'b1;
        while (got < n && guard < 400) begin
            @(negedge clk);
            guard++;
            if (c0_gnt || c1_gnt) got++;
        end
        @(posedge clk); #1;
        c0_req = 1'b0;
        c1_req = 1'b0;
        check_val("both_grants", 64'(got), 64'(n));
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // Behavioural SPI master: busy from the cycle after start, beats from the second busy cycle.
    initial begin
        spi_busy = 1'b0; spi_wr_req = 1'b0; spi_rd_vld = 1'b0; spi_rd_data = 8'h00;
        m_active = 1'b0; m_cnt = 0; m_left = 0;
        forever begin
            @(posedge clk); #1;
            spi_wr_req = 1'b0;
            spi_rd_vld = 1'b0;
            if (!rst) begin
                m_active = 1'b0;
                spi_busy = 1'b0;
            end else if (m_active) begin
                m_cnt++;
                if (m_cnt > m_busy_len) begin
                    m_active = 1'b0;
                    spi_busy = 1'b0;
                end else begin
                    spi_busy = 1'b1;
                    if (m_cnt >= 2 && m_left > 0) begin
                        m_left--;
                        if (m_read) begin
                            spi_rd_vld  = 1'b1;
                            spi_rd_data = 8'hA0 + 8'(m_beats - m_left);
                        end else begin
                            spi_wr_req = 1'b1;
                        end
                    end
                end
            end else if (spi_start && !m_never) begin
                m_active = 1'b1;
                m_cnt = 0;
                m_left = m_beats;
            end
        end
    end

    // Output monitor: pops the scoreboard at each start and checks routing and completion.
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                if (prev_start) check_val("start_width", 64'(spi_start), 64'(0));
                if (spi_start) begin
                    check_val("start_expected", 64'(exp_q.size() > 0), 64'(1));
                    if (exp_q.size() > 0) begin
                        cur = exp_q.pop_front();
                        check_val("gnt_client", 64'({c1_gnt, c0_gnt}), cur.client ? 64'(2) : 64'(1));
                        check_val("spi_cmd", 64'(spi_cmd), 64'(cur.cmd));
                        check_val("spi_addr", 64'(spi_addr), 64'(cur.addr));
                        check_val("spi_length", 64'(spi_length), 64'(cur.len));
                        txn_open = 1'b1;
                        start_cyc = cyc;
                        gap_from_done = cyc - done_cyc;
                    end
                end else if (c0_gnt || c1_gnt) begin
                    check_val("gnt_without_start", 64'({c1_gnt, c0_gnt}), 64'(0));
                end
                if (c0_rd_vld) begin
                    rd_cnt0++;
                    check_val("rd_owner0", 64'(cur.client), 64'(0));
                    check_val("rd_data0", 64'(c0_rd_data), 64'(spi_rd_data));
                end
                if (c1_rd_vld) begin
                    rd_cnt1++;
                    check_val("rd_owner1", 64'(cur.client), 64'(1));
                    check_val("rd_data1", 64'(c1_rd_data), 64'(spi_rd_data));
                end
                if (c0_wr_req) begin
                    wr_cnt0++;
                    check_val("wr_owner0", 64'(cur.client), 64'(0));
                    check_val("wr_data0", 64'(spi_wr_data), 64'(c0_wr_data));
                end
                if (c1_wr_req) begin
                    wr_cnt1++;
                    check_val("wr_owner1", 64'(cur.client), 64'(1));
                    check_val("wr_data1", 64'(spi_wr_data), 64'(c1_wr_data));
                end
                if (c0_done || c1_done) begin
                    check_val("done_client", 64'({c1_done, c0_done}), cur.client ? 64'(2) : 64'(1));
                    check_val("done_err", 64'({c1_err, c0_err}),
                              cur.err ? (cur.client ? 64'(2) : 64'(1)) : 64'(0));
                    txn_open = 1'b0;
                    done_cyc = cyc;
                end
            end
            prev_start = spi_start;
        end
    end

    initial begin
        int c;
        int guard;
        rst = 1'b0;
        c0_req = 1'b0; c1_req = 1'b0;
        c0_cmd = 8'h00; c0_addr = '0; c0_length = '0; c0_wr_data = 8'h3C;
        c1_cmd = 8'h00; c1_addr = '0; c1_length = '0; c1_wr_data = 8'h55;
        rd_cnt0 = 0; rd_cnt1 = 0; wr_cnt0 = 0; wr_cnt1 = 0;

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        check_val("rst_strobes", 64'(strobes_s), 64'(0));
        check_val("rst_desc", 64'(desc_s), 64'(0));
        rst = 1'b1;
        repeat (2) @(posedge clk);

        // Single read transaction from client 0.
        m_busy_len = 40; m_beats = 5; m_read = 1'b1; m_never = 1'b0;
        c0_cmd = 8'h03; c0_addr = 24'hAABBCC; c0_length = 12'd5;
        push_exp(1'b0, 1'b0);
        req_one(1'b0, "single");
        wait_quiet("single");
        check_val("single_rd0", 64'(rd_cnt0), 64'(5));
        check_val("single_rd1", 64'(rd_cnt1), 64'(0));

        // Simultaneous requests from reset.
        do_reset();
        m_busy_len = 3; m_beats = 0;
        c0_cmd = 8'h0A; c0_addr = 24'h000100; c0_length = 12'd1;
        c1_cmd = 8'h1B; c1_addr = 24'h000200; c1_length = 12'd2;
`ifdef SPI_ARB_RR_EN
        push_exp(1'b0, 1'b0); push_exp(1'b1, 1'b0); push_exp(1'b0, 1'b0); push_exp(1'b1, 1'b0);
        run_both(4);
`else
        push_exp(1'b0, 1'b0); push_exp(1'b0, 1'b0); push_exp(1'b0, 1'b0);
        run_both(3);
`endif
        wait_quiet("both");

        // Write routing with client 1 as owner.
        rd_cnt0 = 0; rd_cnt1 = 0; wr_cnt0 = 0; wr_cnt1 = 0;
        m_busy_len = 6; m_beats = 3; m_read = 1'b0;
        c1_cmd = 8'h02; c1_addr = 24'h001000; c1_length = 12'd3;
        push_exp(1'b1, 1'b0);
        req_one(1'b1, "write");
        wait_quiet("write");
        check_val("write_wr1", 64'(wr_cnt1), 64'(3));
        check_val("write_wr0", 64'(wr_cnt0), 64'(0));

        // Busy never rises: done+err after BUSY_TIMEOUT+1 cycles.
        m_never = 1'b1;
        c0_cmd = 8'h9F; c0_addr = 24'h000000; c0_length = 12'd1;
        push_exp(1'b0, 1'b1);
        req_one(1'b0, "timeout");
        wait_quiet("timeout");
        check_val("timeout_cycles", 64'(done_cyc - start_cyc), 64'(BUSY_TIMEOUT + 1));
        m_never = 1'b0;

        // Client 1 requests while client 0 is running.
        m_busy_len = 20; m_beats = 0; m_read = 1'b1;
        c0_cmd = 8'h05; c0_addr = 24'h123456; c0_length = 12'd4;
        push_exp(1'b0, 1'b0);
        req_one(1'b0, "run_c0");
        repeat (5) @(posedge clk);
        #1;
        c1_cmd = 8'h06; c1_addr = 24'h654321; c1_length = 12'd7;
        push_exp(1'b1, 1'b0);
        c1_req = 1'b1;
        guard = 0;
        do begin
            @(negedge clk);
            guard++;
        end while (!c1_gnt && guard < 100);
        #1;
        check_val("run_gap", 64'(gap_from_done), 64'(2));
        @(posedge clk); #1;
        c1_req = 1'b0;
        wait_quiet("run");

        // Reset during RUN while the master streams read beats.
        m_busy_len = 30; m_beats = 20; m_read = 1'b1;
        c0_cmd = 8'h0B; c0_addr = 24'hC0FFEE; c0_length = 12'd20;
        push_exp(1'b0, 1'b0);
        req_one(1'b0, "rst_run");
        repeat (6) @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        check_val("rst_mid_strobes", 64'(strobes_s), 64'(0));
        check_val("rst_mid_desc", 64'(desc_s), 64'(0));
        exp_q.delete();
        txn_open = 1'b0;
        c0_req = 1'b1;
        push_exp(1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        c = cyc;
        rst = 1'b1;
        guard = 0;
        do begin
            @(negedge clk);
            guard++;
        end while (!c0_gnt && guard < 100);
        #1;
        check_val("restart_lat", 64'(start_cyc), 64'(c + 1));
        @(posedge clk); #1;
        c0_req = 1'b0;
        wait_quiet("restart");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
